// File: rtl/la_trace_decoder.sv
// Run-length trace decoder: expands {repeat_count, sample} packets into one sample per cycle with a timestamp.
// Latency: a packet accepted at edge N presents its first sample in cycle N+1; 1 sample/cycle sustained.
// Backpressure: s_tready is only high when idle or while the final sample of the loaded run is handshaking.
//
// Ports:
//   axis_clk, axis_rst      clock and synchronous active-high reset
//   dec_enable              gates packet acceptance only; a loaded run always drains
//   s_t*                    AXI-Stream trace input (tuser/tstrb/tkeep ignored)
//   wf_*                    reconstructed sample stream with valid/ready
//   stat_pkt_cnt/null_cnt   saturating counts of accepted packets / null packets
module la_trace_decoder #(
    parameter int DATA_W = 24,
    parameter int RC_W   = 8,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   dec_enable,
    input  logic [RC_W+DATA_W-1:0] s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [1:0]             s_tuser,
    input  logic [3:0]             s_tstrb,
    input  logic [3:0]             s_tkeep,
    output logic [DATA_W-1:0]      wf_data,
    output logic                   wf_unknown,
    output logic [TS_W-1:0]        wf_time,
    output logic                   wf_run_end,
    output logic                   wf_burst_last,
    output logic                   wf_valid,
    input  logic                   wf_ready,
    output logic [CNT_W-1:0]       stat_pkt_cnt,
    output logic [CNT_W-1:0]       stat_null_cnt
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [RC_W-1:0]  RC_ONE  = 1;
    localparam logic [TS_W-1:0]  TS_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic                unknown_q, unknown_d;
    logic                last_q, last_d;
    logic [RC_W-1:0]     remaining_q, remaining_d;
    logic [TS_W-1:0]     time_q, time_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]    null_cnt_q, null_cnt_d;

    logic                sample_hs;
    logic                accept;
    logic                run_final;
    logic [RC_W-1:0]     pkt_rc;
    logic                pkt_null;

    // Sideband fields carry nothing the decoder needs.
    logic unused_sideband;
    assign unused_sideband = ^{s_tuser, s_tstrb, s_tkeep};

    assign pkt_rc    = s_tdata[RC_W+DATA_W-1:DATA_W];
    assign pkt_null  = (pkt_rc == '0);
    assign run_final = (state_q == RUN) && (remaining_q == RC_ONE);
    assign sample_hs = wf_valid && wf_ready;

    // Combinational from wf_ready so the next run loads on the same edge the
    // current one finishes, giving gapless output across packets.
    assign s_tready = dec_enable && !axis_rst &&
                      ((state_q == IDLE) || (sample_hs && run_final));
    assign accept   = s_tvalid && s_tready;

    // Outputs come straight from the run register; forced quiet when idle.
    assign wf_valid      = (state_q == RUN);
    assign wf_data       = wf_valid ? value_q : '0;
    assign wf_unknown    = wf_valid && unknown_q;
    assign wf_run_end    = run_final;
    assign wf_burst_last = run_final && last_q;
    assign wf_time       = time_q;
    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_null_cnt = null_cnt_q;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        unknown_d   = unknown_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        time_d      = time_q;
        pkt_cnt_d   = pkt_cnt_q;
        null_cnt_d  = null_cnt_q;

        if (sample_hs) begin
            time_d      = time_q + TS_ONE;
            remaining_d = remaining_q - RC_ONE;
            if (run_final) begin
                state_d = IDLE;
            end
        end

        // A load overrides the decrement/idle transition of the finishing run.
        if (accept) begin
            state_d = RUN;
            last_d  = s_tlast;
            if (pkt_cnt_q != '1) begin
                pkt_cnt_d = pkt_cnt_q + CNT_ONE;
            end
            if (pkt_null) begin
                // Overflow gap: one unknown cycle, data field disregarded.
                value_d     = '0;
                unknown_d   = 1'b1;
                remaining_d = RC_ONE;
                if (null_cnt_q != '1) begin
                    null_cnt_d = null_cnt_q + CNT_ONE;
                end
            end else begin
                value_d     = s_tdata[DATA_W-1:0];
                unknown_d   = 1'b0;
                remaining_d = pkt_rc;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q     <= IDLE;
            value_q     <= '0;
            unknown_q   <= 1'b0;
            last_q      <= 1'b0;
            remaining_q <= '0;
            time_q      <= '0;
            pkt_cnt_q   <= '0;
            null_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            unknown_q   <= unknown_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            time_q      <= time_d;
            pkt_cnt_q   <= pkt_cnt_d;
            null_cnt_q  <= null_cnt_d;
        end
    end

endmodule

// File: tb/tb_la_trace_decoder.sv
module tb_la_trace_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [23:0] wf_data;
    logic        wf_unknown;
    logic [31:0] wf_time;
    logic        wf_run_end;
    logic        wf_burst_last;
    logic        wf_valid;
    logic        wf_ready;
    logic [15:0] pkt_cnt;
    logic [15:0] null_cnt;

    int tests = 0;
    int fails = 0;

    la_trace_decoder dut (
        .axis_clk      (clk),
        .axis_rst      (rst),
        .dec_enable    (en),
        .s_tdata       (tdata),
        .s_tvalid      (tvalid),
        .s_tready      (tready),
        .s_tlast       (tlast),
        .s_tuser       (2'b00),
        .s_tstrb       (4'hF),
        .s_tkeep       (4'hF),
        .wf_data       (wf_data),
        .wf_unknown    (wf_unknown),
        .wf_time       (wf_time),
        .wf_run_end    (wf_run_end),
        .wf_burst_last (wf_burst_last),
        .wf_valid      (wf_valid),
        .wf_ready      (wf_ready),
        .stat_pkt_cnt  (pkt_cnt),
        .stat_null_cnt (null_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, v;
        logic [31:0] d;
        logic        last, rdy;
        logic        tr, val;
        logic [23:0] wd;
        logic        unk;
        logic [31:0] t;
        logic        re, bl;
        logic [15:0] pkt, nul;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic v, logic [31:0] d, logic l, logic rdy,
                                logic tr, logic val, logic [23:0] wd, logic unk, logic [31:0] t,
                                logic re, logic bl, logic [15:0] pkt, logic [15:0] nul);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.d = d; x.last = l; x.rdy = rdy;
        x.tr = tr; x.val = val; x.wd = wd; x.unk = unk; x.t = t;
        x.re = re; x.bl = bl; x.pkt = pkt; x.nul = nul;
        return x;
    endfunction

    // Inputs change on the falling edge; checks happen 1 time unit later,
    // well before the next rising edge.
    task automatic drive(input logic r, input logic e, input logic v, input logic [31:0] d,
                         input logic l, input logic rdy);
        @(negedge clk);
        rst = r; en = e; tvalid = v; tdata = d; tlast = l; wf_ready = rdy;
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [92:0] outs();
        return {tready, wf_valid, wf_data, wf_unknown, wf_time, wf_run_end, wf_burst_last,
                pkt_cnt, null_cnt};
    endfunction

    initial begin
        int n;
        int cyc;
        rst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; wf_ready = 1'b0;

        drive(1, 0, 0, 32'h0, 0, 0);
        drive(1, 1, 1, 32'h03ABCDEF, 0, 1);
        chk("tready_in_reset", {127'b0, tready}, 128'd0);
        drive(0, 0, 0, 32'h0, 0, 1);
        chk("reset_state", {35'b0, outs()},
            {35'b0, 1'b0, 1'b0, 24'h0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 16'd0});

        // rst en v data last rdy | tready valid data unk time run_end burst_last pkt null
        // Single run of 3 samples.
        vecs.push_back(mk(0,1,1,32'h03ABCDEF,0,1, 1,0,24'h0,     0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 0,1,24'hABCDEF,0,0, 0,0, 1,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 0,1,24'hABCDEF,0,1, 0,0, 1,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'hABCDEF,0,2, 1,0, 1,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,0,24'h0,     0,3, 0,0, 1,0));
        vecs.push_back(mk(1,1,0,32'h0,       0,1, 0,0,24'h0,     0,3, 0,0, 1,0));
        // Back-to-back runs, second carries tlast.
        vecs.push_back(mk(0,1,1,32'h02000001,0,1, 1,0,24'h0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,1,32'h01000002,1,1, 0,1,24'h1,0,0, 0,0, 1,0));
        vecs.push_back(mk(0,1,1,32'h01000002,1,1, 1,1,24'h1,0,1, 1,0, 1,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'h2,0,2, 1,1, 2,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,0,24'h0,0,3, 0,0, 2,0));
        vecs.push_back(mk(1,1,0,32'h0,       0,1, 0,0,24'h0,0,3, 0,0, 2,0));
        // Null packet between two single-sample runs.
        vecs.push_back(mk(0,1,1,32'h01000005,0,1, 1,0,24'h0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,1,32'h00000000,0,1, 1,1,24'h5,0,0, 1,0, 1,0));
        vecs.push_back(mk(0,1,1,32'h01000006,0,1, 1,1,24'h0,1,1, 1,0, 2,1));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'h6,0,2, 1,0, 3,1));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,0,24'h0,0,3, 0,0, 3,1));
        // Null with non-zero data field and tlast.
        vecs.push_back(mk(0,1,1,32'h00FFFFFF,1,1, 1,0,24'h0,0,3, 0,0, 3,1));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'h0,1,3, 1,1, 4,2));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,0,24'h0,0,4, 0,0, 4,2));
        vecs.push_back(mk(1,1,0,32'h0,       0,1, 0,0,24'h0,0,4, 0,0, 4,2));
        // dec_enable dropped mid-run with next packet pending.
        vecs.push_back(mk(0,1,1,32'h03000009,0,1, 1,0,24'h0, 0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,1,32'h01000011,0,1, 0,1,24'h9, 0,0, 0,0, 1,0));
        vecs.push_back(mk(0,0,1,32'h01000011,0,1, 0,1,24'h9, 0,1, 0,0, 1,0));
        vecs.push_back(mk(0,0,1,32'h01000011,0,1, 0,1,24'h9, 0,2, 1,0, 1,0));
        vecs.push_back(mk(0,0,1,32'h01000011,0,1, 0,0,24'h0, 0,3, 0,0, 1,0));
        vecs.push_back(mk(0,1,1,32'h01000011,0,1, 1,0,24'h0, 0,3, 0,0, 1,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'h11,0,3, 1,0, 2,0));
        // wf_ready backpressure holds outputs and blocks acceptance.
        vecs.push_back(mk(0,1,1,32'h02000033,0,0, 1,0,24'h0, 0,4, 0,0, 2,0));
        vecs.push_back(mk(0,1,1,32'h01000044,0,0, 0,1,24'h33,0,4, 0,0, 3,0));
        vecs.push_back(mk(0,1,1,32'h01000044,0,1, 0,1,24'h33,0,4, 0,0, 3,0));
        vecs.push_back(mk(0,1,1,32'h01000044,0,0, 0,1,24'h33,0,5, 1,0, 3,0));
        vecs.push_back(mk(0,1,1,32'h01000044,0,1, 1,1,24'h33,0,5, 1,0, 3,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,1,24'h44,0,6, 1,0, 4,0));
        vecs.push_back(mk(0,1,0,32'h0,       0,1, 1,0,24'h0, 0,7, 0,0, 4,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].last, vecs[i].rdy);
            chk($sformatf("vec%0d", i), {35'b0, outs()},
                {35'b0, vecs[i].tr, vecs[i].val, vecs[i].wd, vecs[i].unk, vecs[i].t,
                 vecs[i].re, vecs[i].bl, vecs[i].pkt, vecs[i].nul});
        end

        // Reset in the middle of a 4-sample run.
        drive(1, 1, 0, 32'h0, 0, 1);
        drive(0, 1, 1, 32'h04000007, 0, 1);
        chk("midrst_accept", {127'b0, tready}, 128'd1);
        drive(0, 1, 0, 32'h0, 0, 1);
        chk("midrst_s0", {95'b0, wf_valid, wf_data, wf_time}, {95'b0, 1'b1, 24'h7, 32'd0});
        drive(0, 1, 0, 32'h0, 0, 1);
        chk("midrst_s1", {95'b0, wf_valid, wf_data, wf_time}, {95'b0, 1'b1, 24'h7, 32'd1});
        drive(1, 1, 1, 32'h01000008, 0, 0);
        chk("midrst_tready", {127'b0, tready}, 128'd0);
        drive(0, 1, 1, 32'h01000008, 0, 1);
        chk("midrst_flushed", {95'b0, wf_valid, wf_time, tready}, {95'b0, 1'b0, 32'd0, 1'b1});
        drive(0, 1, 0, 32'h0, 0, 1);
        chk("midrst_next", {95'b0, wf_valid, wf_data, wf_time}, {95'b0, 1'b1, 24'h8, 32'd0});

        // 255-sample run with wf_ready toggling every cycle; next packet pending.
        drive(1, 1, 0, 32'h0, 0, 1);
        drive(0, 1, 1, 32'hFF123456, 0, 1);
        chk("long_accept", {127'b0, tready}, 128'd1);
        n = 0;
        cyc = 0;
        while (n < 255 && cyc < 1000) begin
            drive(0, 1, 1, 32'h01000099, 0, cyc[0]);
            if (wf_valid && wf_ready) begin
                chk($sformatf("long_s%0d", n), {72'b0, wf_data, wf_time},
                    {72'b0, 24'h123456, 32'(n)});
                chk($sformatf("long_tready%0d", n), {127'b0, tready},
                    {127'b0, (n == 254)});
                n++;
            end else begin
                chk($sformatf("long_stall%0d", cyc), {126'b0, wf_valid, tready}, {126'b0, 2'b10});
            end
            cyc++;
        end
        chk("long_count", 128'(n), 128'd255);
        drive(0, 1, 0, 32'h0, 0, 1);
        chk("long_next", {95'b0, wf_valid, wf_data, wf_time}, {95'b0, 1'b1, 24'h99, 32'd255});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
